// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: BHT of 2-bit saturating counters with a tagged BTB.
// Combinational fetch lookup, EX-stage resolution/update, mispredict detection and statistics counters.
module branch_predictor #(
  parameter int BHT_ENTRIES = 64,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic            ex_branch_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int TW = XLEN - IW - 2;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  logic [BHT_ENTRIES-1:0] r_valid;
  logic [TW-1:0]          r_tag    [BHT_ENTRIES];
  logic [XLEN-1:0]        r_target [BHT_ENTRIES];
  logic [1:0]             r_ctr    [BHT_ENTRIES];
  logic [31:0]            r_branch_cnt;
  logic [31:0]            r_mispredict_cnt;

  logic [IW-1:0] w_if_idx;
  logic [TW-1:0] w_if_tag;
  logic          w_if_hit;
  logic [IW-1:0] w_ex_idx;
  logic [TW-1:0] w_ex_tag;
  logic          w_ex_hit;
  logic          w_upd;
  logic          w_mispredict;

  assign w_if_idx = if_pc_i[IW+1:2];
  assign w_if_tag = if_pc_i[XLEN-1:IW+2];
  assign w_ex_idx = ex_pc_i[IW+1:2];
  assign w_ex_tag = ex_pc_i[XLEN-1:IW+2];

  assign w_if_hit = r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
  assign w_ex_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);

  assign pred_taken_o  = w_if_hit & r_ctr[w_if_idx][1];
  assign pred_target_o = pred_taken_o ? r_target[w_if_idx] : (if_pc_i + PC_INC);

  assign w_upd = ex_valid_i & ex_branch_i;

  // A non-branch carrying a taken prediction hit a stale or aliased entry and must be redirected.
  assign w_mispredict = (w_upd & ((ex_pred_taken_i != ex_taken_i) |
                                  (ex_taken_i & (ex_pred_target_i != ex_target_i)))) |
                        (ex_valid_i & ~ex_branch_i & ex_pred_taken_i);

  assign mispredict_o     = w_mispredict;
  assign redirect_pc_o    = (w_upd & ex_taken_i) ? ex_target_i : (ex_pc_i + PC_INC);
  assign branch_cnt_o     = r_branch_cnt;
  assign mispredict_cnt_o = r_mispredict_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (w_upd) begin
      if (w_ex_hit) begin
        if (ex_taken_i) begin
          r_target[w_ex_idx] <= ex_target_i;
          if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'b01;
        end else begin
          if (r_ctr[w_ex_idx] != 2'b00) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'b01;
        end
      end else if (ex_taken_i) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= ex_target_i;
        r_ctr[w_ex_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt     <= 32'd0;
      r_mispredict_cnt <= 32'd0;
    end else begin
      if (w_upd && (r_branch_cnt != 32'hFFFF_FFFF))
        r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_mispredict && (r_mispredict_cnt != 32'hFFFF_FFFF))
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: cold miss, saturation, aliasing,
// target mismatch, non-branch flush, bubble, same-cycle lookup and mid-update reset.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i, ex_branch_i, ex_taken_i, ex_pred_taken_i;
  logic [31:0] ex_pc_i, ex_target_i, ex_pred_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o, branch_cnt_o, mispredict_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(.BHT_ENTRIES(64), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .if_pc_i(if_pc_i),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .ex_valid_i(ex_valid_i), .ex_branch_i(ex_branch_i), .ex_pc_i(ex_pc_i),
    .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid_i = v; ex_branch_i = br; ex_pc_i = pc; ex_taken_i = tk;
    ex_target_i = tgt; ex_pred_taken_i = ptk; ex_pred_target_i = ptgt;
    #1;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1; if_pc_i = 32'h0000_0100; idle_ex();
    step(); step();
    rst = 1'b0; #1;
    checks++; if (branch_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_branch_cnt got=%h exp=%h", branch_cnt_o, 32'd0); end
    checks++; if (mispredict_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_misp_cnt got=%h exp=%h", mispredict_cnt_o, 32'd0); end
    checks++; if (pred_taken_o !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%b exp=0", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h0000_0104) begin failures++; $display("FAIL reset_pred_target got=%h exp=%h", pred_target_o, 32'h104); end
    checks++; if (mispredict_o !== 1'b0) begin failures++; $display("FAIL reset_mispredict got=%b exp=0", mispredict_o); end
    if_pc_i = 32'hFFFF_FFFC; #1;
    checks++; if (pred_target_o !== 32'h0000_0000) begin failures++; $display("FAIL pc_wrap got=%h exp=%h", pred_target_o, 32'h0); end
  endtask

  task automatic test_cold_miss();
    step();
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    checks++; if (mispredict_o !== 1'b1) begin failures++; $display("FAIL cold_mispredict got=%b exp=1", mispredict_o); end
    checks++; if (redirect_pc_o !== 32'h80) begin failures++; $display("FAIL cold_redirect got=%h exp=%h", redirect_pc_o, 32'h80); end
    step(); idle_ex();
    if_pc_i = 32'h100; #1;
    checks++; if (pred_taken_o !== 1'b1) begin failures++; $display("FAIL cold_pred_taken got=%b exp=1", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h80) begin failures++; $display("FAIL cold_pred_target got=%h exp=%h", pred_target_o, 32'h80); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      checks++; if (mispredict_o !== 1'b0) begin failures++; $display("FAIL sat_taken_%0d got=%b exp=0", i, mispredict_o); end
      step();
    end
    drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    checks++; if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h104) begin failures++; $display("FAIL sat_nt1_flush got=%b/%h exp=1/%h", mispredict_o, redirect_pc_o, 32'h104); end
    step(); idle_ex();
    checks++; if (pred_taken_o !== 1'b1) begin failures++; $display("FAIL sat_after_nt1 got=%b exp=1", pred_taken_o); end
    drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    step(); idle_ex();
    checks++; if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h104) begin failures++; $display("FAIL sat_after_nt2 got=%b/%h exp=0/%h", pred_taken_o, pred_target_o, 32'h104); end
    checks++; if (branch_cnt_o !== 32'd6 || mispredict_cnt_o !== 32'd3) begin failures++; $display("FAIL sat_counts got=%0d/%0d exp=6/3", branch_cnt_o, mispredict_cnt_o); end
  endtask

  task automatic test_alias();
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    drive_ex(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (mispredict_o !== 1'b0) begin failures++; $display("FAIL alias_mispredict got=%b exp=0", mispredict_o); end
    step(); idle_ex();
    if_pc_i = 32'h100; #1;
    checks++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h80) begin failures++; $display("FAIL alias_keep got=%b/%h exp=1/%h", pred_taken_o, pred_target_o, 32'h80); end
    if_pc_i = 32'h200; #1;
    checks++; if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h204) begin failures++; $display("FAIL alias_miss got=%b/%h exp=0/%h", pred_taken_o, pred_target_o, 32'h204); end
    checks++; if (branch_cnt_o !== 32'd8 || mispredict_cnt_o !== 32'd4) begin failures++; $display("FAIL alias_counts got=%0d/%0d exp=8/4", branch_cnt_o, mispredict_cnt_o); end
  endtask

  task automatic test_target_mismatch();
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'hC0, 1'b1, 32'h80);
    checks++; if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'hC0) begin failures++; $display("FAIL tgt_flush got=%b/%h exp=1/%h", mispredict_o, redirect_pc_o, 32'hC0); end
    step(); idle_ex();
    if_pc_i = 32'h100; #1;
    checks++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'hC0) begin failures++; $display("FAIL tgt_update got=%b/%h exp=1/%h", pred_taken_o, pred_target_o, 32'hC0); end
  endtask

  task automatic test_non_branch();
    drive_ex(1'b1, 1'b0, 32'h300, 1'b0, 32'h0, 1'b1, 32'hC0);
    checks++; if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h304) begin failures++; $display("FAIL nonbr_flush got=%b/%h exp=1/%h", mispredict_o, redirect_pc_o, 32'h304); end
    step(); idle_ex();
    checks++; if (branch_cnt_o !== 32'd9 || mispredict_cnt_o !== 32'd6) begin failures++; $display("FAIL nonbr_counts got=%0d/%0d exp=9/6", branch_cnt_o, mispredict_cnt_o); end
    checks++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'hC0) begin failures++; $display("FAIL nonbr_no_update got=%b/%h exp=1/%h", pred_taken_o, pred_target_o, 32'hC0); end
  endtask

  task automatic test_bubble();
    drive_ex(1'b0, 1'b1, 32'h200, 1'b1, 32'h40, 1'b1, 32'h0);
    checks++; if (mispredict_o !== 1'b0) begin failures++; $display("FAIL bubble_mispredict got=%b exp=0", mispredict_o); end
    step(); idle_ex();
    if_pc_i = 32'h200; #1;
    checks++; if (pred_taken_o !== 1'b0 || branch_cnt_o !== 32'd9) begin failures++; $display("FAIL bubble_no_update got=%b/%0d exp=0/9", pred_taken_o, branch_cnt_o); end
  endtask

  task automatic test_back_to_back();
    if_pc_i = 32'h104;
    drive_ex(1'b1, 1'b1, 32'h104, 1'b1, 32'h40, 1'b0, 32'h0);
    checks++; if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h108) begin failures++; $display("FAIL b2b_no_bypass got=%b/%h exp=0/%h", pred_taken_o, pred_target_o, 32'h108); end
    step();
    drive_ex(1'b1, 1'b1, 32'h104, 1'b1, 32'h40, 1'b1, 32'h40);
    checks++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h40 || mispredict_o !== 1'b0) begin failures++; $display("FAIL b2b_second got=%b/%h/%b exp=1/%h/0", pred_taken_o, pred_target_o, mispredict_o, 32'h40); end
    step(); idle_ex();
    checks++; if (branch_cnt_o !== 32'd11 || mispredict_cnt_o !== 32'd7) begin failures++; $display("FAIL b2b_counts got=%0d/%0d exp=11/7", branch_cnt_o, mispredict_cnt_o); end
  endtask

  task automatic test_mid_reset();
    drive_ex(1'b1, 1'b1, 32'h108, 1'b1, 32'h20, 1'b0, 32'h0);
    #1 rst = 1'b1; #1;
    checks++; if (branch_cnt_o !== 32'd0 || mispredict_cnt_o !== 32'd0) begin failures++; $display("FAIL rst_async_counts got=%0d/%0d exp=0/0", branch_cnt_o, mispredict_cnt_o); end
    step();
    idle_ex(); rst = 1'b0; #1;
    if_pc_i = 32'h108; #1;
    checks++; if (pred_taken_o !== 1'b0) begin failures++; $display("FAIL rst_no_update got=%b exp=0", pred_taken_o); end
    if_pc_i = 32'h100; #1;
    checks++; if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h104) begin failures++; $display("FAIL rst_cleared got=%b/%h exp=0/%h", pred_taken_o, pred_target_o, 32'h104); end
    step();
    checks++; if (branch_cnt_o !== 32'd0 || mispredict_cnt_o !== 32'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", branch_cnt_o, mispredict_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_saturation();
    test_alias();
    test_target_mismatch();
    test_non_branch();
    test_bubble();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
